// File: rtl/load_store_unit.sv
// load_store_unit: data-side LSU between the memory-access stage and the
// data master bus. Single outstanding transaction: IDLE -> CMD -> RESP.
// Write data is lane-replicated, read data is right-justified and
// zero-filled above the access size.
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] lsu_addr,
   input  logic [31:0] lsu_wdata,
   input  logic [1:0]  lsu_cmd,
   input  logic        lsu_rnw,
   output logic [31:0] lsu_rdata,
   output logic        lsu_busy,
   output logic        lsu_err_align,
   output logic        lsu_err_bus,
   output logic [31:0] o_MAddr,
   output logic [2:0]  o_MCmd,
   output logic [31:0] o_MData,
   output logic [3:0]  o_MByteEn,
   input  logic        i_SCmdAccept,
   input  logic [31:0] i_SData,
   input  logic [1:0]  i_SResp
);

   // LSU command encoding
   localparam logic [1:0] LSU_IDLE  = 2'b00;
   localparam logic [1:0] LSU_BYTE  = 2'b01;
   localparam logic [1:0] LSU_HWORD = 2'b10;
   localparam logic [1:0] LSU_WORD  = 2'b11;

   // Bus command / response encoding
   localparam logic [2:0] BUS_IDLE  = 3'b000;
   localparam logic [2:0] BUS_WRITE = 3'b001;
   localparam logic [2:0] BUS_READ  = 3'b010;
   localparam logic [1:0] RSP_NULL  = 2'b00;
   localparam logic [1:0] RSP_DVA   = 2'b01;
   localparam logic [1:0] RSP_ERR   = 2'b11;

   // FSM states
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_CMD  = 2'b01;
   localparam logic [1:0] ST_RESP = 2'b10;

   logic [1:0]  state_q,   state_d;
   logic [31:0] maddr_q,   maddr_d;
   logic [2:0]  mcmd_q,    mcmd_d;
   logic [31:0] mdata_q,   mdata_d;
   logic [3:0]  mbyteen_q, mbyteen_d;
   logic [1:0]  size_q,    size_d;
   logic [1:0]  off_q,     off_d;
   logic        rnw_q,     rnw_d;
   logic [31:0] rdata_q,   rdata_d;
   logic        errbus_q,  errbus_d;

   logic        aligned;
   logic        req_valid;
   logic [3:0]  be_new;
   logic [31:0] wdata_rep;
   logic [31:0] rd_shift;
   logic [31:0] rd_steer;

   // Alignment check on the incoming command (BYTE is always aligned)
   always_comb begin
      aligned = 1'b0;
      case (lsu_cmd)
         LSU_BYTE:  aligned = 1'b1;
         LSU_HWORD: aligned = ~lsu_addr[0];
         LSU_WORD:  aligned = (lsu_addr[1:0] == 2'b00);
         default:   aligned = 1'b0;
      endcase
   end

   // A new command is only looked at while the FSM is idle
   assign req_valid     = (state_q == ST_IDLE) && (lsu_cmd != LSU_IDLE);
   assign lsu_err_align = req_valid && !aligned;
   // Combinational term stalls the requesting cycle itself
   assign lsu_busy      = (state_q != ST_IDLE) || ((lsu_cmd != LSU_IDLE) && aligned);

   // Byte enables and lane-replicated write data for the new request
   always_comb begin
      be_new    = 4'b0000;
      wdata_rep = lsu_wdata;
      case (lsu_cmd)
         LSU_BYTE: begin
            be_new    = 4'b0001 << lsu_addr[1:0];
            wdata_rep = {4{lsu_wdata[7:0]}};
         end
         LSU_HWORD: begin
            be_new    = 4'b0011 << lsu_addr[1:0];
            wdata_rep = {2{lsu_wdata[15:0]}};
         end
         LSU_WORD: begin
            be_new    = 4'b1111;
            wdata_rep = lsu_wdata;
         end
         default: begin
            be_new    = 4'b0000;
            wdata_rep = lsu_wdata;
         end
      endcase
   end

   // Right-justify read data using the latched offset, then zero-fill by size
   assign rd_shift = i_SData >> {off_q, 3'b000};
   always_comb begin
      rd_steer = rd_shift;
      case (size_q)
         LSU_BYTE:  rd_steer = {24'h000000, rd_shift[7:0]};
         LSU_HWORD: rd_steer = {16'h0000, rd_shift[15:0]};
         default:   rd_steer = rd_shift;
      endcase
   end

   // Next-state: request capture, accept wait, response handling
   always_comb begin
      state_d   = state_q;
      maddr_d   = maddr_q;
      mcmd_d    = mcmd_q;
      mdata_d   = mdata_q;
      mbyteen_d = mbyteen_q;
      size_d    = size_q;
      off_d     = off_q;
      rnw_d     = rnw_q;
      rdata_d   = rdata_q;
      errbus_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_valid && aligned) begin
               state_d   = ST_CMD;
               maddr_d   = {lsu_addr[31:2], 2'b00};
               mcmd_d    = lsu_rnw ? BUS_READ : BUS_WRITE;
               mdata_d   = wdata_rep;
               mbyteen_d = be_new;
               size_d    = lsu_cmd;
               off_d     = lsu_addr[1:0];
               rnw_d     = lsu_rnw;
            end
         end
         ST_CMD: begin
            // Bus fields stay put until the slave takes the command
            if (i_SCmdAccept) begin
               state_d = ST_RESP;
               mcmd_d  = BUS_IDLE;
            end
         end
         ST_RESP: begin
            if (i_SResp != RSP_NULL) begin
               state_d = ST_IDLE;
               if ((i_SResp == RSP_DVA) && rnw_q)
                  rdata_d = rd_steer;
               if (i_SResp == RSP_ERR)
                  errbus_d = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            mcmd_d  = BUS_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any outstanding transaction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         maddr_q   <= '0;
         mcmd_q    <= BUS_IDLE;
         mdata_q   <= '0;
         mbyteen_q <= '0;
         size_q    <= LSU_IDLE;
         off_q     <= '0;
         rnw_q     <= 1'b0;
         rdata_q   <= '0;
         errbus_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         maddr_q   <= maddr_d;
         mcmd_q    <= mcmd_d;
         mdata_q   <= mdata_d;
         mbyteen_q <= mbyteen_d;
         size_q    <= size_d;
         off_q     <= off_d;
         rnw_q     <= rnw_d;
         rdata_q   <= rdata_d;
         errbus_q  <= errbus_d;
      end
   end

   assign o_MAddr     = maddr_q;
   assign o_MCmd      = mcmd_q;
   assign o_MData     = mdata_q;
   assign o_MByteEn   = mbyteen_q;
   assign lsu_rdata   = rdata_q;
   assign lsu_err_bus = errbus_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: reset, aligned loads/stores with
// accept/response waits, misalignment, bus error, reset mid-transaction.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
   logic [1:0]  lsu_cmd;
   logic        lsu_rnw, lsu_busy, lsu_err_align, lsu_err_bus;
   logic [31:0] o_MAddr, o_MData, i_SData;
   logic [2:0]  o_MCmd;
   logic [3:0]  o_MByteEn;
   logic        i_SCmdAccept;
   logic [1:0]  i_SResp;

   int n_chk = 0;
   int n_err = 0;

   // transaction observations
   int          t_cyc, t_lat, t_errs;
   logic        t_efall;
   logic [31:0] t_rdata, r_maddr, r_mdata;
   logic [3:0]  r_be;
   logic [2:0]  r_mcmd;
   logic        r_stable;

   load_store_unit dut (
      .clk(clk), .rst(rst),
      .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_cmd(lsu_cmd), .lsu_rnw(lsu_rnw),
      .lsu_rdata(lsu_rdata), .lsu_busy(lsu_busy),
      .lsu_err_align(lsu_err_align), .lsu_err_bus(lsu_err_bus),
      .o_MAddr(o_MAddr), .o_MCmd(o_MCmd), .o_MData(o_MData), .o_MByteEn(o_MByteEn),
      .i_SCmdAccept(i_SCmdAccept), .i_SData(i_SData), .i_SResp(i_SResp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // per-cycle sample at negedge: first busy-low cycle, bus-error pulses
   task automatic smp();
      if (!lsu_busy && t_lat < 0) begin
         t_lat   = t_cyc;
         t_efall = lsu_err_bus;
         t_rdata = lsu_rdata;
      end
      if (lsu_err_bus) t_errs++;
      t_cyc++;
   endtask

   task automatic txn(input logic [1:0] cmd, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic rnw, input int acc_wait, input int resp_wait,
                      input logic [1:0] resp, input logic [31:0] sdata);
      t_cyc = 0; t_lat = -1; t_errs = 0; t_efall = 1'b0; t_rdata = '0; r_stable = 1'b1;
      @(posedge clk); #1;
      lsu_cmd = cmd; lsu_addr = addr; lsu_wdata = wdata; lsu_rnw = rnw;
      @(negedge clk); smp();
      @(posedge clk); #1;
      lsu_cmd = 2'b00;
      for (int i = 0; i <= acc_wait; i++) begin
         i_SCmdAccept = (i == acc_wait);
         @(negedge clk); smp();
         if (i == 0) begin
            r_maddr = o_MAddr; r_mdata = o_MData; r_be = o_MByteEn; r_mcmd = o_MCmd;
         end else if (o_MAddr !== r_maddr || o_MData !== r_mdata ||
                      o_MByteEn !== r_be || o_MCmd !== r_mcmd) begin
            r_stable = 1'b0;
         end
         @(posedge clk); #1;
      end
      i_SCmdAccept = 1'b0;
      for (int i = 0; i <= resp_wait; i++) begin
         i_SResp = (i == resp_wait) ? resp : 2'b00;
         i_SData = sdata;
         @(negedge clk); smp();
         @(posedge clk); #1;
      end
      i_SResp = 2'b00; i_SData = '0;
      repeat (2) begin
         @(negedge clk); smp();
         @(posedge clk); #1;
      end
   endtask

   initial begin
      rst = 1'b1; lsu_addr = '0; lsu_wdata = '0; lsu_cmd = 2'b00; lsu_rnw = 1'b0;
      i_SCmdAccept = 1'b0; i_SData = '0; i_SResp = 2'b00;
      #12;
      chk("rst_mcmd",   {29'd0, o_MCmd}, 32'd0);
      chk("rst_maddr",  o_MAddr, 32'd0);
      chk("rst_mdata",  o_MData, 32'd0);
      chk("rst_be",     {28'd0, o_MByteEn}, 32'd0);
      chk("rst_rdata",  lsu_rdata, 32'd0);
      chk("rst_busy",   {31'd0, lsu_busy}, 32'd0);
      chk("rst_errbus", {31'd0, lsu_err_bus}, 32'd0);
      @(negedge clk); rst = 1'b0;

      // word load, minimum latency
      txn(2'b11, 32'h1000, 32'h0, 1'b1, 0, 0, 2'b01, 32'hDEADBEEF);
      chk("wl_lat",   t_lat, 3);
      chk("wl_maddr", r_maddr, 32'h1000);
      chk("wl_be",    {28'd0, r_be}, 32'hF);
      chk("wl_mcmd",  {29'd0, r_mcmd}, 32'd2);
      chk("wl_rdata", t_rdata, 32'hDEADBEEF);
      chk("wl_errs",  t_errs, 0);

      // byte load at offset 3
      txn(2'b01, 32'h1003, 32'h0, 1'b1, 0, 0, 2'b01, 32'h80112233);
      chk("bl_maddr", r_maddr, 32'h1000);
      chk("bl_be",    {28'd0, r_be}, 32'h8);
      chk("bl_rdata", t_rdata, 32'h00000080);

      // halfword load at offset 2
      txn(2'b10, 32'h1002, 32'h0, 1'b1, 0, 0, 2'b01, 32'h80112233);
      chk("hl_be",    {28'd0, r_be}, 32'hC);
      chk("hl_rdata", t_rdata, 32'h00008011);

      // halfword store, 3 accept-wait cycles, 1 response-wait cycle
      txn(2'b10, 32'h2002, 32'hAAAA1234, 1'b0, 3, 1, 2'b01, 32'hFFFFFFFF);
      chk("hs_lat",    t_lat, 7);
      chk("hs_maddr",  r_maddr, 32'h2000);
      chk("hs_mdata",  r_mdata, 32'h12341234);
      chk("hs_be",     {28'd0, r_be}, 32'hC);
      chk("hs_mcmd",   {29'd0, r_mcmd}, 32'd1);
      chk("hs_stable", {31'd0, r_stable}, 32'd1);
      chk("hs_rdata",  t_rdata, 32'h00008011);

      // misaligned word and halfword
      @(posedge clk); #1;
      lsu_cmd = 2'b11; lsu_addr = 32'h3001; lsu_rnw = 1'b1;
      @(negedge clk);
      chk("ma_w_err",  {31'd0, lsu_err_align}, 32'd1);
      chk("ma_w_busy", {31'd0, lsu_busy}, 32'd0);
      @(posedge clk); #1;
      lsu_cmd = 2'b10; lsu_addr = 32'h3003;
      @(negedge clk);
      chk("ma_w_mcmd", {29'd0, o_MCmd}, 32'd0);
      chk("ma_h_err",  {31'd0, lsu_err_align}, 32'd1);
      chk("ma_h_busy", {31'd0, lsu_busy}, 32'd0);
      @(posedge clk); #1;
      lsu_cmd = 2'b00;
      @(negedge clk);
      chk("ma_h_mcmd", {29'd0, o_MCmd}, 32'd0);
      chk("ma_end",    {31'd0, lsu_err_align}, 32'd0);
      chk("ma_idle",   {31'd0, lsu_busy}, 32'd0);

      // bus error on a word load
      txn(2'b11, 32'h1000, 32'h0, 1'b1, 0, 0, 2'b11, 32'h55555555);
      chk("be_lat",   t_lat, 3);
      chk("be_errs",  t_errs, 1);
      chk("be_fall",  {31'd0, t_efall}, 32'd1);
      chk("be_rdata", t_rdata, 32'h00008011);

      // reset in CMD before accept; later DVA must be ignored
      @(posedge clk); #1;
      lsu_cmd = 2'b11; lsu_addr = 32'h40; lsu_rnw = 1'b1;
      @(posedge clk); #1;
      lsu_cmd = 2'b00;
      @(negedge clk);
      chk("mr_mcmd0", {29'd0, o_MCmd}, 32'd2);
      #1 rst = 1'b1;
      #1;
      chk("mr_mcmd",  {29'd0, o_MCmd}, 32'd0);
      chk("mr_busy",  {31'd0, lsu_busy}, 32'd0);
      chk("mr_maddr", o_MAddr, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; i_SResp = 2'b01; i_SData = 32'h12345678;
      @(negedge clk);
      chk("mr_busy2", {31'd0, lsu_busy}, 32'd0);
      @(posedge clk); #1;
      i_SResp = 2'b00; i_SData = '0;
      @(negedge clk);
      chk("mr_rdata", lsu_rdata, 32'd0);
      chk("mr_mcmd2", {29'd0, o_MCmd}, 32'd0);
      chk("mr_ebus",  {31'd0, lsu_err_bus}, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
